goertzel_tone_gen: RTL and testbench



---
 rtl/goertzel_tone_gen.sv | 126 ++++++++++++
 tb/tb_goertzel_tone_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/goertzel_tone_gen.sv
// goertzel_tone_gen: recursive-oscillator sine burst generator.
// Produces y[0]=0, y[1]=init, y[n]=((coef*y[n-1])>>>FRAC)-y[n-2] for len
// samples on a valid/ready stream, marking the final sample with last and
// pulsing done once the final sample has been accepted.
// Optional build macro GOERTZEL_TONE_GEN_SAT_EN: when defined the recursion
// result saturates to the W-bit signed range, otherwise it wraps.
module goertzel_tone_gen #(
  parameter int W     = 16,
  parameter int CW    = 18,
  parameter int FRAC  = 16,
  parameter int LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [CW-1:0] coef,
  input  logic signed [W-1:0]  init,
  input  logic [LEN_W-1:0]     len,
  output logic                 ready,
  output logic                 sample_valid,
  output logic signed [W-1:0]  sample,
  input  logic                 sample_ready,
  output logic                 last,
  output logic                 done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [CW-1:0] coef_q, coef_d;
  logic signed [W-1:0]  s1_q, s1_d;
  logic signed [W-1:0]  next_q, next_d;
  logic [LEN_W-1:0]     remain_q, remain_d;

  // y[n-2] is not kept separately: at the moment the recursion is evaluated
  // it is exactly the sample currently presented (s1), so s1 serves as both.
  logic signed [W+CW-1:0] prodFull;
  logic signed [W+CW:0]   prodShifted;
  logic signed [W+CW:0]   prevWide;
  logic signed [W+CW:0]   diffWide;
  logic signed [W-1:0]    recurResult;

  assign prodFull    = coef_q * next_q;
  assign prodShifted = prodFull >>> FRAC;
  assign prevWide    = s1_q;
  assign diffWide    = prodShifted - prevWide;

`ifdef GOERTZEL_TONE_GEN_SAT_EN
  // Clamp the wide recursion result into the signed W-bit range
  always_comb begin
    recurResult = diffWide[W-1:0];
    if (diffWide[W+CW:W-1] != {(CW+2){diffWide[W+CW]}}) begin
      recurResult = diffWide[W+CW] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Keep only the low W bits of the recursion result (two's-complement wrap)
  always_comb begin
    recurResult = W'(diffWide);
  end
`endif

  // Next-state logic for the burst FSM and the oscillator registers
  always_comb begin
    state_d  = state_q;
    coef_d   = coef_q;
    s1_d     = s1_q;
    next_d   = next_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          coef_d   = coef;
          s1_d     = '0;
          next_d   = init;
          remain_d = len;
          state_d  = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample_ready) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            s1_d   = next_q;
            next_d = recurResult;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      coef_q   <= '0;
      s1_q     <= '0;
      next_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      coef_q   <= coef_d;
      s1_q     <= s1_d;
      next_q   <= next_d;
      remain_q <= remain_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign sample_valid = (state_q == RUN);
  assign sample       = s1_q;
  assign last         = (state_q == RUN) && (remain_q == LEN_W'(1));
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Directed testbench for goertzel_tone_gen with hand-computed sequences.
module tb_goertzel_tone_gen;

   logic               clk;
   logic               rst;
   logic               start;
   logic signed [17:0] coef;
   logic signed [15:0] init;
   logic [11:0]        len;
   logic               ready;
   logic               sample_valid;
   logic signed [15:0] sample;
   logic               sample_ready;
   logic               last;
   logic               done;

   int testsRun;
   int failCount;
   int expSeq [0:15];

   goertzel_tone_gen #(.W(16), .CW(18), .FRAC(16), .LEN_W(12)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .coef         (coef),
      .init         (init),
      .len          (len),
      .ready        (ready),
      .sample_valid (sample_valid),
      .sample       (sample),
      .sample_ready (sample_ready),
      .last         (last),
      .done         (done)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts the check and reports any miscompare
   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present a start request once the block is idle, held for one edge
   task automatic applyStimulus(input int c, input int y1, input int n);
      int waited;
      waited = 0;
      while (!ready && waited < 20) begin
         stepCycle();
         waited++;
      end
      if (!ready) checkOutput("ready_wait", 0, 1);
      coef  = 18'(c);
      init  = 16'(y1);
      len   = 12'(n);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
   endtask

   // Walk a burst against expSeq, optionally stalling or poking start mid-burst
   task automatic runBurst(input string name, input int n, input int stallIdx,
                           input int stallLen, input int pokeIdx);
      for (int i = 0; i < n; i++) begin
         if (i == stallIdx) begin
            sample_ready = 1'b0;
            for (int s = 0; s < stallLen; s++) begin
               checkOutput($sformatf("%s_stall%0d_valid", name, s), int'(sample_valid), 1);
               checkOutput($sformatf("%s_stall%0d_sample", name, s), int'(sample), expSeq[i]);
               checkOutput($sformatf("%s_stall%0d_last", name, s), int'(last), 0);
               stepCycle();
            end
            sample_ready = 1'b1;
         end
         checkOutput($sformatf("%s_s%0d_valid", name, i), int'(sample_valid), 1);
         checkOutput($sformatf("%s_s%0d_sample", name, i), int'(sample), expSeq[i]);
         checkOutput($sformatf("%s_s%0d_last", name, i), int'(last), (i == n - 1) ? 1 : 0);
         checkOutput($sformatf("%s_s%0d_ready", name, i), int'(ready), 0);
         if (i == pokeIdx) begin
            start = 1'b1;
            coef  = 18'sd0;
            init  = 16'sd7;
            len   = 12'd1;
         end
         stepCycle();
         start = 1'b0;
      end
      checkOutput({name, "_done"}, int'(done), 1);
      checkOutput({name, "_done_ready"}, int'(ready), 0);
      checkOutput({name, "_done_valid"}, int'(sample_valid), 0);
      stepCycle();
      checkOutput({name, "_post_done"}, int'(done), 0);
      checkOutput({name, "_post_ready"}, int'(ready), 1);
   endtask

   // Directed test sequence
   initial begin
      testsRun     = 0;
      failCount    = 0;
      rst          = 1'b1;
      start        = 1'b0;
      coef         = '0;
      init         = '0;
      len          = '0;
      sample_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready", int'(ready), 1);
      checkOutput("rst_valid", int'(sample_valid), 0);
      checkOutput("rst_sample", int'(sample), 0);
      checkOutput("rst_last", int'(last), 0);
      checkOutput("rst_done", int'(done), 0);
      rst = 1'b0;
      stepCycle();

      // coef=0: quarter-rate sine
      expSeq[0] = 0; expSeq[1] = 1000; expSeq[2] = 0; expSeq[3] = -1000; expSeq[4] = 0;
      applyStimulus(0, 1000, 5);
      runBurst("c0", 5, -1, 0, -1);

      // coef=1.0 (2cos60): sixth-rate sine, with a start poked mid-burst
      expSeq[0] = 0; expSeq[1] = 1000; expSeq[2] = 1000; expSeq[3] = 0;
      expSeq[4] = -1000; expSeq[5] = -1000; expSeq[6] = 0;
      applyStimulus(65536, 1000, 7);
      runBurst("c60", 7, -1, 0, 2);
      checkOutput("c60_no_restart_valid", int'(sample_valid), 0);

      // Backpressure: stall three cycles while sample=1000
      expSeq[0] = 0; expSeq[1] = 1000; expSeq[2] = 0; expSeq[3] = -1000; expSeq[4] = 0;
      applyStimulus(0, 1000, 5);
      runBurst("bp", 5, 1, 3, -1);

      // Overflowing recursion: 59999 either clamps or wraps
      expSeq[0] = 0; expSeq[1] = 30000;
`ifdef GOERTZEL_TONE_GEN_SAT_EN
      expSeq[2] = 32767;
`else
      expSeq[2] = -5537;
`endif
      applyStimulus(131071, 30000, 3);
      runBurst("ovf", 3, -1, 0, -1);

      // len=0: straight to done with no samples
      applyStimulus(0, 1000, 0);
      checkOutput("len0_valid", int'(sample_valid), 0);
      checkOutput("len0_done", int'(done), 1);
      checkOutput("len0_ready", int'(ready), 0);
      stepCycle();
      checkOutput("len0_post_done", int'(done), 0);
      checkOutput("len0_post_ready", int'(ready), 1);
      checkOutput("len0_post_valid", int'(sample_valid), 0);

      // Asynchronous reset after two samples, then a fresh burst
      applyStimulus(0, 1000, 5);
      checkOutput("ar_s0", int'(sample), 0);
      stepCycle();
      checkOutput("ar_s1", int'(sample), 1000);
      stepCycle();
      checkOutput("ar_s2_valid", int'(sample_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_ready", int'(ready), 1);
      checkOutput("ar_valid", int'(sample_valid), 0);
      checkOutput("ar_sample", int'(sample), 0);
      checkOutput("ar_last", int'(last), 0);
      checkOutput("ar_done", int'(done), 0);
      #2;
      rst = 1'b0;
      stepCycle();
      checkOutput("ar_idle_done", int'(done), 0);
      expSeq[0] = 0; expSeq[1] = 1000; expSeq[2] = 0; expSeq[3] = -1000; expSeq[4] = 0;
      applyStimulus(0, 1000, 5);
      runBurst("ar_fresh", 5, -1, 0, -1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
